// File: rtl/link_tx_scheduler.sv
// ---------------------------------------------------------------------------
// link_tx_scheduler
//   Drives the transmit side of a serial link encoder. The link passes
//   through three states:
//     OFF   : encoder idle, requesters stalled.
//     ALIGN : ALIGN_LEN comma words so the far end can lock on.
//     RUN   : one word per cycle. Priority is SKIP (every SKIP_PERIOD RUN
//             cycles), then the granted requester's data, then COMMA as idle.
//   Two requesters share the link through a round-robin arbiter. A receive
//   error monitor forces realignment after ERR_LIMIT errored cycles inside
//   one skip window.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   link_en                  1 = link enabled, 0 = force OFF
//   reqN_valid/data/ready    requester N valid/ready handshake (N = 0, 1);
//                            ready is combinational
//   rx_code_err/rx_disp_err  per-byte decoder error flags
//   enc_ena/enc_k/enc_data   registered encoder word
//   state                    OFF=0, ALIGN=1, RUN=2
//   realign_cnt              saturating count of error-triggered realignments
// ---------------------------------------------------------------------------
module link_tx_scheduler #(
  parameter int DW          = 16,
  parameter int ALIGN_LEN   = 8,
  parameter int SKIP_PERIOD = 256,
  parameter int ERR_LIMIT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          link_en,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [1:0]    rx_code_err,
  input  logic [1:0]    rx_disp_err,
  output logic          enc_ena,
  output logic          enc_k,
  output logic [DW-1:0] enc_data,
  output logic [1:0]    state,
  output logic [7:0]    realign_cnt
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Comma and skip characters repeated in every byte lane.
  localparam logic [DW-1:0] COMMA = {(DW/8){8'hBC}};
  localparam logic [DW-1:0] SKIP  = {(DW/8){8'h1C}};

  localparam int ALW = (ALIGN_LEN   > 1) ? $clog2(ALIGN_LEN)   : 1;
  localparam int SKW = (SKIP_PERIOD > 1) ? $clog2(SKIP_PERIOD) : 1;
  localparam int EW  = $clog2(ERR_LIMIT + 1);

  logic [1:0]    state_q, state_d;
  logic [ALW-1:0] align_cnt;
  logic [SKW-1:0] skip_cnt;
  logic [EW-1:0]  err_cnt, err_inc;
  logic           last_grant;   // 1 = requester 1 was granted last
  logic           run, skip_due, open, grant0, grant1, any_err, hit_limit;
  logic           ena_d, k_d;
  logic [DW-1:0]  data_d;

  assign state = state_q;

  // NOTE: every signal written in an always_comb block gets a default at the
  // top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    run      = (state_q == ST_RUN);
    skip_due = run && (skip_cnt == SKW'(SKIP_PERIOD - 1));
    // Round-robin: a lone valid wins; on contention the one not granted last.
    grant0   = req0_valid && (!req1_valid || last_grant);
    grant1   = req1_valid && !grant0;
    open     = run && link_en && !skip_due;
    req0_ready = open && grant0;
    req1_ready = open && grant1;

    any_err   = |{rx_code_err, rx_disp_err};
    err_inc   = (any_err && (err_cnt != EW'(ERR_LIMIT))) ? err_cnt + 1'b1 : err_cnt;
    hit_limit = run && (err_inc == EW'(ERR_LIMIT));

    state_d = state_q;
    ena_d   = 1'b0;
    k_d     = 1'b0;
    data_d  = '0;
    if (!link_en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_ALIGN;
        ST_ALIGN: begin
          ena_d  = 1'b1;
          k_d    = 1'b1;
          data_d = COMMA;
          if (align_cnt == ALW'(ALIGN_LEN - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          ena_d = 1'b1;
          if (skip_due) begin
            k_d    = 1'b1;
            data_d = SKIP;
          end else if (req0_ready && req0_valid) begin
            data_d = req0_data;
          end else if (req1_ready && req1_valid) begin
            data_d = req1_data;
          end else begin
            k_d    = 1'b1;
            data_d = COMMA;
          end
          // The word chosen above is still sent in the realignment cycle.
          if (hit_limit) state_d = ST_ALIGN;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_OFF;
      enc_ena     <= 1'b0;
      enc_k       <= 1'b0;
      enc_data    <= '0;
      align_cnt   <= '0;
      skip_cnt    <= '0;
      err_cnt     <= '0;
      realign_cnt <= '0;
      last_grant  <= 1'b1;
    end else begin
      state_q  <= state_d;
      enc_ena  <= ena_d;
      enc_k    <= k_d;
      enc_data <= data_d;

      // Counters sit at zero outside their own state, so entry clears them.
      align_cnt <= (state_q == ST_ALIGN && state_d == ST_ALIGN) ? align_cnt + 1'b1 : '0;
      skip_cnt  <= (run && state_d == ST_RUN) ? (skip_due ? '0 : skip_cnt + 1'b1) : '0;
      err_cnt   <= (run && state_d == ST_RUN && !skip_due) ? err_inc : '0;

      if (link_en && hit_limit && realign_cnt != 8'hFF)
        realign_cnt <= realign_cnt + 1'b1;

      if (req0_ready && req0_valid)      last_grant <= 1'b0;
      else if (req1_ready && req1_valid) last_grant <= 1'b1;
    end
  end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_link_tx_scheduler
//   Directed bench for link_tx_scheduler (DW=16, ALIGN_LEN=8, SKIP_PERIOD=16,
//   ERR_LIMIT=4): reset values, alignment, round-robin arbitration, skip
//   insertion, error-driven realignment, link_en drop and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_link_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_en;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [1:0]  rx_code_err, rx_disp_err;
  logic        enc_ena, enc_k;
  logic [15:0] enc_data;
  logic [1:0]  state;
  logic [7:0]  realign_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  link_tx_scheduler #(
    .DW(16), .ALIGN_LEN(8), .SKIP_PERIOD(16), .ERR_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .link_en(link_en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rx_code_err(rx_code_err), .rx_disp_err(rx_disp_err),
    .enc_ena(enc_ena), .enc_k(enc_k), .enc_data(enc_data),
    .state(state), .realign_cnt(realign_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Registered outputs are sampled 1 ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_w, w, seq;
  logic        exp_k, k, e0, e1, skip;

  initial begin
    rst = 1'b0; link_en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    rx_code_err = '0; rx_disp_err = '0;

    // Reset values
    #3;
    check("rst_state", state, 0);
    check("rst_enc_ena", enc_ena, 0);
    check("rst_enc_k", enc_k, 0);
    check("rst_enc_data", enc_data, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_realign", realign_cnt, 0);

    #19;             // t=22, between edges
    rst = 1'b1;
    link_en = 1'b1;

    // Alignment: 8 ALIGN cycles, commas appear one cycle behind the state
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("align%0d_state", i), state, 1);
      if (i == 0) begin
        check("align0_enc_ena", enc_ena, 0);
      end else begin
        check($sformatf("align%0d_data", i), enc_data, 16'hBCBC);
        check($sformatf("align%0d_k", i), enc_k, 1);
        check($sformatf("align%0d_ena", i), enc_ena, 1);
      end
      if (i == 3) begin
        req0_valid = 1'b1;
        #1;
        check("align_ready0", req0_ready, 0);
        req0_valid = 1'b0;
      end
    end

    // RUN: c=0..5 arbitration, c=6..39 skip insertion, c=40..43 errors
    exp_w = 16'hBCBC; exp_k = 1'b1; seq = 16'h0100;
    for (int c = 0; c < 44; c++) begin
      cycle();
      check($sformatf("run%0d_state", c), state, 2);
      check($sformatf("run%0d_data", c), enc_data, exp_w);
      check($sformatf("run%0d_k", c), enc_k, exp_k);
      check($sformatf("run%0d_ena", c), enc_ena, 1);
      skip = ((c % 16) == 15);
      if (c < 6) begin
        req0_valid = 1'b1; req0_data = 16'h0001;
        req1_valid = 1'b1; req1_data = 16'h0002;
        e0 = ((c % 2) == 0); e1 = !e0;
        w  = e0 ? 16'h0001 : 16'h0002; k = 1'b0;
      end else if (c < 40) begin
        req0_valid = 1'b1; req0_data = seq;
        req1_valid = 1'b0;
        e0 = !skip; e1 = 1'b0;
        if (skip) begin
          w = 16'h1C1C; k = 1'b1;
        end else begin
          w = seq; k = 1'b0; seq = seq + 16'd1;
        end
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        rx_code_err = 2'b01;
        e0 = 1'b0; e1 = 1'b0;
        w = 16'hBCBC; k = 1'b1;
      end
      #1;
      check($sformatf("run%0d_ready0", c), req0_ready, e0);
      check($sformatf("run%0d_ready1", c), req1_ready, e1);
      exp_w = w; exp_k = k;
    end

    // Fourth errored cycle forces realignment; errors stay on through ALIGN
    cycle();
    check("realign_state", state, 1);
    check("realign_cnt", realign_cnt, 1);
    check("realign_last_word", enc_data, 16'hBCBC);
    for (int i = 1; i < 8; i++) begin
      cycle();
      check($sformatf("realign%0d_state", i), state, 1);
      check($sformatf("realign%0d_data", i), enc_data, 16'hBCBC);
      check($sformatf("realign%0d_k", i), enc_k, 1);
    end

    // Back in RUN: 3 errored cycles must not realign
    cycle();
    check("rerun_state", state, 2);
    check("rerun_realign_cnt", realign_cnt, 1);
    check("rerun_data", enc_data, 16'hBCBC);
    rx_code_err = 2'b00; rx_disp_err = 2'b10;
    for (int d = 1; d < 3; d++) begin
      cycle();
      check($sformatf("err%0d_state", d), state, 2);
    end
    cycle();
    check("err3_state", state, 2);
    rx_disp_err = 2'b00;
    req1_valid = 1'b1; req1_data = 16'h00AA;
    #1;
    check("solo_ready1", req1_ready, 1);

    // link_en drop with req1 still valid
    cycle();
    check("drop_pre_state", state, 2);
    check("drop_pre_data", enc_data, 16'h00AA);
    check("drop_pre_k", enc_k, 0);
    link_en = 1'b0;
    #1;
    check("drop_ready1", req1_ready, 0);
    cycle();
    check("off_state", state, 0);
    check("off_enc_ena", enc_ena, 0);
    check("off_enc_data", enc_data, 0);
    check("off_realign_cnt", realign_cnt, 1);
    req1_valid = 1'b0;
    link_en = 1'b1;

    // Asynchronous reset in the middle of ALIGN
    cycle();
    check("re_align_state", state, 1);
    cycle();
    cycle();
    check("mid_align_ena", enc_ena, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_enc_ena", enc_ena, 0);
    check("arst_enc_k", enc_k, 0);
    check("arst_enc_data", enc_data, 0);
    check("arst_realign", realign_cnt, 0);
    #3;
    rst = 1'b1;
    cycle();
    check("resume_state", state, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
